// File: rtl/src_mem_pkg.sv
// Shared types and default sizes for the MDR/MAR memory interface.
// MDR_TIMEOUT_EN selects the optional ack-timeout behaviour (default size below).
package src_mem_pkg;

   localparam int unsigned DATA_W_DEF         = 32;
   localparam int unsigned ADDR_W_DEF         = 9;
   localparam int unsigned TIMEOUT_CYCLES_DEF = 15;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

endpackage

// File: rtl/mem_req_fsm.sv
// Single-outstanding request/ack sequencer: state, latched op, done/err pulses.
// With MDR_TIMEOUT_EN a WAIT-cycle counter aborts a request after TIMEOUT_CYCLES.
module mem_req_fsm
   import src_mem_pkg::*;
`ifdef MDR_TIMEOUT_EN
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
)
`endif
(
   input  logic clk,
   input  logic reset,
   input  logic read,
   input  logic write,
   input  logic ack,
   output logic req,
   output logic we,
   output logic busy,
   output logic done,
   output logic err,
   output logic rd_cpl_c
);

   state_t state;
   logic   op_we;

`ifdef MDR_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt;
   logic             expire_c;

   // cnt holds the number of WAIT cycles already completed before this edge
   assign expire_c = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign err = 1'b0;
`endif

   // A read completing this edge tells the top to capture mem_rdata into the MDR
   assign rd_cpl_c = (state == WAIT) && ack && !op_we;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         op_we <= 1'b0;
         req   <= 1'b0;
         we    <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
`ifdef MDR_TIMEOUT_EN
         err   <= 1'b0;
         cnt   <= '0;
`endif
      end else begin
         done <= 1'b0;
`ifdef MDR_TIMEOUT_EN
         err  <= 1'b0;
`endif
         case (state)
            IDLE: begin
               // read has priority when both commands arrive together
               if (read || write) begin
                  state <= WAIT;
                  op_we <= !read;
                  req   <= 1'b1;
                  we    <= !read;
                  busy  <= 1'b1;
`ifdef MDR_TIMEOUT_EN
                  cnt   <= '0;
`endif
               end
            end
            WAIT: begin
               if (ack) begin
                  state <= IDLE;
                  req   <= 1'b0;
                  we    <= 1'b0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
`ifdef MDR_TIMEOUT_EN
               else if (expire_c) begin
                  state <= IDLE;
                  req   <= 1'b0;
                  we    <= 1'b0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  err   <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/mdr_mem_interface.sv
// MAR/MDR holding stage between the datapath bus and word-addressed memory.
// Define MDR_TIMEOUT_EN to enable the ack timeout (TIMEOUT_CYCLES).
module mdr_mem_interface
   import src_mem_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
`ifdef MDR_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
)(
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] bus_in,
   input  logic              mar_in,
   input  logic              mdr_in,
   input  logic              read,
   input  logic              write,
   output logic [DATA_W-1:0] mdr_bus_out,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_req,
   output logic              mem_we,
   input  logic              mem_ack,
   output logic              busy,
   output logic              done,
   output logic              err
);

   logic [ADDR_W-1:0] mar;
   logic [DATA_W-1:0] mdr;
   logic              rd_cpl_c;

   mem_req_fsm
`ifdef MDR_TIMEOUT_EN
   #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   )
`endif
   u_fsm (
      .clk      (clk),
      .reset    (reset),
      .read     (read),
      .write    (write),
      .ack      (mem_ack),
      .req      (mem_req),
      .we       (mem_we),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .rd_cpl_c (rd_cpl_c)
   );

   // MAR/MDR are frozen while a request is in flight so memory sees stable values
   always_ff @(posedge clk) begin
      if (reset) begin
         mar <= '0;
         mdr <= '0;
      end else if (busy) begin
         if (rd_cpl_c) begin
            mdr <= mem_rdata;
         end
      end else begin
         if (mar_in) begin
            mar <= bus_in[ADDR_W-1:0];
         end
         if (mdr_in) begin
            mdr <= bus_in;
         end
      end
   end

   assign mdr_bus_out = mdr;
   assign mem_addr    = mar;
   assign mem_wdata   = mdr;

endmodule

// File: doc/mdr_mem_interface.md
# mdr_mem_interface

Memory-side stage that produces the MDR operand consumed by the datapath bus (`BusMuxIn_MDR`) and accepts addresses and store data from `BusMuxOut`. It holds the MAR and MDR registers and runs a single-outstanding request/acknowledge handshake to word-addressed memory. Reads load the MDR from memory; writes store the MDR to memory.

## Interface
- `DATA_W`, 32, data width of bus, MDR and memory words
- `ADDR_W`, 9, MAR width; 512-word memory
- `TIMEOUT_CYCLES`, 15, maximum wait for `mem_ack` (used only with `MDR_TIMEOUT_EN`)

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high
- `bus_in`  in  DATA_W  from `BusMuxOut`
- `mar_in`  in  1  load MAR from `bus_in[ADDR_W-1:0]`
- `mdr_in`  in  1  load MDR from `bus_in`
- `read`  in  1  one-cycle pulse; start a memory read
- `write`  in  1  one-cycle pulse; start a memory write
- `mdr_bus_out`  out  DATA_W  MDR contents, to `BusMuxIn_MDR`
- `mem_addr`  out  ADDR_W  MAR contents
- `mem_wdata`  out  DATA_W  MDR contents
- `mem_rdata`  in  DATA_W  read data, valid when `mem_ack` is high
- `mem_req`  out  1  request valid
- `mem_we`  out  1  1 = write, 0 = read; valid while `mem_req` is high
- `mem_ack`  in  1  memory completion, one cycle
- `busy`  out  1  transaction in flight
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  one-cycle timeout pulse, coincident with `done`

## Operation
- **Reset.** MAR = 0, MDR = 0, state = IDLE. All of `mem_req`, `mem_we`, `busy`, `done` and `err` read 0.
- **States.**
  - IDLE: on `read` or `write`, latch the operation into `op_we` and go to WAIT.
  - WAIT: on `mem_ack`, go to IDLE.
  - With `MDR_TIMEOUT_EN`, WAIT also goes to IDLE on counter expiry.
- **Outputs in WAIT.**
  - `mem_req` = 1, `mem_we` = `op_we`, `busy` = 1.
  - `mem_addr` and `mem_wdata` stay stable, because MAR and MDR are frozen.
- **Read completion.** At the edge where `mem_ack` is high, MDR <= `mem_rdata`.
- **Write completion.** MDR is unchanged.
- **Command priority.** If `read` and `write` are asserted together in IDLE, the read wins.
- **Ignored inputs.**
  - `read` and `write` are ignored while busy.
  - `mar_in` and `mdr_in` are ignored while busy.
  - `mem_ack` is ignored in IDLE.
- **Loads in IDLE.** `mar_in` and `mdr_in` take effect on the same edge as a `read` or `write`. The new MAR/MDR value is the one presented to memory.
- **Outputs are unconditional.** `mdr_bus_out` always shows the MDR; bus selection is handled by the bus mux.

## Timing
- `read`/`write` sampled at edge N:
  - `mem_req` = 1 from cycle N+1.
- `mem_ack` sampled at edge M (M ≥ N+1):
  - MDR is updated.
  - `done` = 1, `busy` = 0 and `mem_req` = 0 during cycle M+1.
- Minimum command-to-`done` latency: 2 cycles.
- A new command is accepted in the same cycle `done` is high.
- `mem_ack` in the first WAIT cycle is legal (zero wait states).
- Reset mid-transaction:
  - At the reset edge, return to IDLE; `mem_req` low in the next cycle.
  - MAR and MDR cleared; no `done` pulse.
  - A late `mem_ack` after reset is ignored.

## Configuration
- **`MDR_TIMEOUT_EN` defined:**
  - A cycle counter of width `$clog2(TIMEOUT_CYCLES+1)` clears on entry to WAIT.
  - If `mem_ack` has not arrived after `TIMEOUT_CYCLES` WAIT cycles, go to IDLE and drop `mem_req`.
  - `done` = 1 and `err` = 1 in the following cycle; MDR unchanged.
  - If `mem_ack` arrives on the expiry cycle, the ack wins and `err` = 0.
- **`MDR_TIMEOUT_EN` undefined:**
  - No counter; WAIT is held indefinitely.
  - `err` is tied to 0.

## Structure
- Package `src_mem_pkg` holds:
  - the state enum (IDLE, WAIT);
  - `DATA_W_DEF` = 32, `ADDR_W_DEF` = 9;
  - the default `TIMEOUT_CYCLES`.
- One sub-module, `mem_req_fsm`: state, `op_we`, timeout counter and the `done`/`err` pulse logic.
- The MAR/MDR registers and their load muxing live in the top-level module.

## Test plan
- **Read:** MAR <= 0x05, `read`, memory acks after 3 wait cycles with 0xDEADBEEF → `mem_req` high for 4 cycles, `mem_we` = 0, `mem_addr` = 0x05, then `mdr_bus_out` = 0xDEADBEEF with a `done` pulse.
- **Write:** MDR <= 0x12345678, MAR <= 0x1FF, `write`, zero-wait ack → `mem_we` = 1, `mem_wdata` = 0x12345678, `done` 2 cycles after `write`, MDR unchanged.
- **Busy-ignore:** during a pending read, pulse `mdr_in` with 0xAAAA0000 and pulse `write` → both ignored; MDR ends with the read data; exactly one `done`.
- **Simultaneous commands:** `read` and `write` in the same cycle → read performed (`mem_we` = 0).
- **Back-to-back:** `read` issued in the `done` cycle → second `mem_req` in the next cycle.
- **Reset mid-WAIT:** `reset` during WAIT, then a late `mem_ack` → `mem_req` = 0 and MDR = 0 after reset; no `done`.
- **Timeout (`MDR_TIMEOUT_EN` only):** no ack → `done` and `err` pulse together 16 cycles after the WAIT entry edge; MDR unchanged.
